fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage for the microprocessor. It owns the program counter and issues one instruction-memory request at a time under a request/acknowledge protocol. Returned instructions are buffered with their PCs in a 2-entry queue and handed downstream over a valid/ready handshake. It feeds the fetch/decode pipeline register and accepts branch redirects from execute.

## Interface
Parameters:
- WIDTH, 32, address and instruction width in bits
- RESET_PC, 0, PC loaded on reset; must be 4-byte aligned

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; reset is asserted when 0 at a rising edge of clk
- branch_taken  in  1  redirect strobe, one cycle
- branch_target  in  WIDTH  redirect address; bits [1:0] ignored and treated as 0
- imem_req  out  1  memory request
- imem_addr  out  WIDTH  request address
- imem_ack  in  1  memory response valid
- imem_rdata  in  WIDTH  instruction; valid with imem_ack
- out_valid  out  1  queue head is valid
- out_ready  in  1  downstream accepts head
- out_instr  out  WIDTH  head instruction
- out_pc  out  WIDTH  head PC
- out_pc_plus4  out  WIDTH  head PC + 4, modulo 2^WIDTH

## Operation
- Registered state:
  - pc (next fetch address)
  - FSM state in {FETCH, DRAIN}
  - queue of 2 entries {pc, instr} with count 0..2
  - req_active flag
- Reset, while reset is 0 at an edge:
  - pc = RESET_PC, count = 0, state = FETCH, req_active = 0.
  - Outputs: imem_req = 0, imem_addr = RESET_PC, out_valid = 0, out_instr/out_pc = 0, out_pc_plus4 = 4.
- Request issue:
  - In FETCH, imem_req = req_active | (count < 2).
  - imem_addr = pc.
  - Once raised, imem_req and imem_addr stay stable until imem_ack.
  - imem_ack may arrive in the same cycle as imem_req (zero-wait) or any later cycle.
  - imem_ack without imem_req is ignored.
- Response, in FETCH with imem_req & imem_ack:
  - Push {pc, imem_rdata}.
  - pc <= pc + 4, wrapping modulo 2^WIDTH.
- Pop: when out_valid & out_ready, remove the head.
  - Push and pop in the same cycle are both performed; count is unchanged.
- Redirect: branch_taken has priority over everything.
  - Queue flushed (count <= 0); any same-cycle pop or push is discarded.
  - pc <= {branch_target[WIDTH-1:2], 2'b00}.
  - If a request is pending without ack this cycle, go to DRAIN. Otherwise stay in FETCH.
- DRAIN:
  - imem_req stays high with the old address until imem_ack.
  - The returned data is discarded.
  - Then go to FETCH; the new pc is requested in the following cycle.
- branch_taken during DRAIN: pc is replaced by the newer target; remain in DRAIN.
- out_valid = (count != 0). All out_* are driven from registered queue state; no combinational path from out_ready or branch_taken.
- reset at 0 mid-request: the outstanding request is abandoned; memory must tolerate the dropped imem_req.

## Timing
- Zero-wait memory, out_ready held 1:
  - reset released at edge E0.
  - imem_req high in the cycle after E0.
  - First push at E1; out_valid = 1 after E1.
  - Sustained throughput: 1 instruction per cycle.
- Memory latency N cycles (ack N cycles after req rises): one instruction per N+1 cycles.
- Queue full (count = 2): imem_req drops in the next cycle unless a request is already pending.
- After a redirect with no pending request, the first instruction from the target appears in out_* 1 cycle later with zero-wait memory.

## Structure
- Package fetch_pkg:
  - state enum {FETCH, DRAIN}
  - INSTR_BYTES = 4
  - QUEUE_DEPTH = 2
- Sub-module fetch_queue: 2-entry synchronous FIFO with push, pop, flush, count and head outputs, parameterised by entry width.
- PC register, FSM and request logic stay in fetch_stage.

## Test plan
- Reset with RESET_PC = 0x100, zero-wait memory, out_ready = 1 -> out_pc sequence 0x100, 0x104, 0x108, ...; out_valid every cycle after the first; out_pc_plus4 = out_pc + 4.
- out_ready = 0 for 6 cycles -> count saturates at 2 and imem_req falls. On release, 0x100 then 0x104 pop in order, with no duplicate or lost PC.
- 3-cycle memory latency -> imem_addr stable while imem_req is high; one instruction per 4 cycles.
- branch_taken with target 0x203 while a request for 0x10C waits for ack:
  - DRAIN entered; the 0x10C data is dropped.
  - Next request is 0x200; out_pc = 0x200 is the first instruction seen downstream.
- branch_taken in the same cycle as a pop and an ack -> queue empty next cycle, pc = target, no stale instruction is ever presented.
- PC = 0xFFFF_FFFC (WIDTH = 32) -> fetched entry has out_pc_plus4 = 0, and the next fetch address is 0. Also: reset at 0 mid-DRAIN -> all outputs return to their reset values at the next edge.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module : fetch_pkg
// Desc   : Shared types and constants for the instruction fetch stage.
// Rev    : 1.0  initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam int INSTR_BYTES = 4;
    localparam int QUEUE_DEPTH = 2;
    localparam int COUNT_W     = $clog2(QUEUE_DEPTH + 1);

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module : fetch_queue
// Desc   : Two-entry synchronous FIFO with flush, holding fetched {pc, instr}.
// Rev    : 1.0  initial release
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DW = 64
)(
    input  logic               clk,
    input  logic               i_reset_n,
    input  logic               i_push,
    input  logic [DW-1:0]      i_push_data,
    input  logic               i_pop,
    input  logic               i_flush,
    output logic [COUNT_W-1:0] o_count,
    output logic [DW-1:0]      o_head
);

    logic [DW-1:0]      r_mem [QUEUE_DEPTH];
    logic               r_rd_ptr;
    logic               r_wr_ptr;
    logic [COUNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != COUNT_W'(QUEUE_DEPTH)) || w_do_pop);

    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + COUNT_W'(1);
                2'b01:   r_count <= r_count - COUNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module : fetch_stage
// Desc   : PC owner, single-outstanding imem requester and 2-entry fetch queue.
// Rev    : 1.0  initial release
// ============================================================================
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_instr,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_pc_plus4
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_pc;
    logic [WIDTH-1:0]   r_drain_addr;
    logic               r_req_active;
    logic               r_run;

    logic               w_req;
    logic [WIDTH-1:0]   w_addr;
    logic               w_push;
    logic               w_pop;
    logic               w_pending;
    logic [WIDTH-1:0]   w_target;
    logic [COUNT_W-1:0] w_count;
    logic [2*WIDTH-1:0] w_head;

    assign w_target  = branch_target & ~WIDTH'(INSTR_BYTES - 1);
    assign w_pending = w_req && !imem_ack;

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_addr      = r_pc;
        case (r_state)
            FETCH: begin
                // r_run keeps the request low until the first edge after reset release
                w_req  = r_run && (r_req_active || (w_count < COUNT_W'(QUEUE_DEPTH)));
                w_addr = r_pc;
                if (branch_taken && w_pending) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_req  = 1'b1;
                w_addr = r_drain_addr;
                if (imem_ack) begin
                    w_state_nxt = FETCH;
                end
            end
            default: begin
                w_state_nxt = FETCH;
            end
        endcase
    end

    assign w_push = (r_state == FETCH) && w_req && imem_ack && !branch_taken;
    assign w_pop  = out_valid && out_ready && !branch_taken;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= FETCH;
            r_pc         <= RESET_PC;
            r_drain_addr <= RESET_PC;
            r_req_active <= 1'b0;
            r_run        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_req_active <= w_pending;
            r_run        <= 1'b1;
            if (branch_taken) begin
                r_pc <= w_target;
            end else if (w_push) begin
                r_pc <= r_pc + WIDTH'(INSTR_BYTES);
            end
            // The abandoned request must keep its address while it drains
            if (branch_taken && (r_state == FETCH) && w_pending) begin
                r_drain_addr <= r_pc;
            end
        end
    end

    fetch_queue #(
        .DW (2 * WIDTH)
    ) u_queue (
        .clk         (clk),
        .i_reset_n   (reset),
        .i_push      (w_push),
        .i_push_data ({r_pc, imem_rdata}),
        .i_pop       (w_pop),
        .i_flush     (branch_taken),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    assign imem_req     = w_req;
    assign imem_addr    = w_addr;
    assign out_valid    = (w_count != '0);
    assign out_pc       = w_head[2*WIDTH-1:WIDTH];
    assign out_instr    = w_head[WIDTH-1:0];
    assign out_pc_plus4 = out_pc + WIDTH'(INSTR_BYTES);

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_fetch_stage
// Desc   : Directed, table-driven self-checking bench for fetch_stage.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

    localparam int NV = 27;

    logic        clk;
    logic        reset;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        ack;
        logic        rdy;
        logic        br;
        logic [31:0] tgt;
        logic        ev;
        logic [31:0] epc;
        logic        ereq;
        logic [31:0] eaddr;
    } vec_t;

    vec_t vecs [NV];

    fetch_stage #(
        .WIDTH    (32),
        .RESET_PC (32'h100)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_pc_plus4  (out_pc_plus4)
    );

    // Memory model: the instruction word at an address is its bitwise complement
    assign imem_rdata = ~imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " imem_req"},     {31'b0, imem_req},  32'h0);
        check({tag, " imem_addr"},    imem_addr,          32'h100);
        check({tag, " out_valid"},    {31'b0, out_valid}, 32'h0);
        check({tag, " out_instr"},    out_instr,          32'h0);
        check({tag, " out_pc"},       out_pc,             32'h0);
        check({tag, " out_pc_plus4"}, out_pc_plus4,       32'h4);
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check({tag, " out_valid"},    {31'b0, out_valid}, 32'h1);
        check({tag, " out_pc"},       out_pc,             pc);
        check({tag, " out_instr"},    out_instr,          ~pc);
        check({tag, " out_pc_plus4"}, out_pc_plus4,       pc + 32'h4);
    endtask

    initial begin
        int waited;
        logic found;

        //          ack   rdy   br    tgt           ev    epc           ereq  eaddr
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h100};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h100,      1'b1, 32'h104};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h104,      1'b1, 32'h108};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h104,      1'b0, 32'h10C};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h104,      1'b0, 32'h10C};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h104,      1'b0, 32'h10C};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h104,      1'b0, 32'h10C};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h104,      1'b0, 32'h10C};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h104,      1'b0, 32'h10C};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h108,      1'b1, 32'h10C};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 32'h203,      1'b0, 32'h0,        1'b1, 32'h10C};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h10C};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h10C};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h200};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h200,      1'b1, 32'h204};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h204};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h204};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h204};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h204,      1'b1, 32'h208};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h208};
        vecs[20] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h208};
        vecs[21] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h208};
        vecs[22] = '{1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b1, 32'h208,      1'b1, 32'h20C};
        vecs[23] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'hFFFFFFFC};
        vecs[24] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFFFFFC, 1'b1, 32'h0};
        vecs[25] = '{1'b0, 1'b0, 1'b1, 32'h40,       1'b1, 32'hFFFFFFFC, 1'b1, 32'h0};
        vecs[26] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0};

        reset         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        imem_ack      = 1'b0;
        out_ready     = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            check($sformatf("v%0d imem_req", i), {31'b0, imem_req}, {31'b0, vecs[i].ereq});
            check($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].eaddr);
            if (vecs[i].ev) begin
                check_head($sformatf("v%0d", i), vecs[i].epc);
            end else begin
                check($sformatf("v%0d out_valid", i), {31'b0, out_valid}, 32'h0);
            end
            imem_ack      = vecs[i].ack;
            out_ready     = vecs[i].rdy;
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].tgt;
        end

        // Last table row leaves the stage in DRAIN; reset must abandon it
        reset         = 1'b0;
        imem_ack      = 1'b0;
        branch_taken  = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid-drain reset");

        // Restart with zero-wait memory: first instruction one cycle after the first request
        reset     = 1'b1;
        imem_ack  = 1'b1;
        out_ready = 1'b1;
        waited    = 0;
        found     = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            waited++;
            if (out_valid) found = 1'b1;
        end
        check("restart valid seen", {31'b0, found}, 32'h1);
        check("restart latency", waited, 32'd2);
        if (found) begin
            check_head("restart h0", 32'h100);
            @(negedge clk);
            check_head("restart h1", 32'h104);
            @(negedge clk);
            check_head("restart h2", 32'h108);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
